// File: rtl/dmem_pkg.sv
// dmem_pkg: default geometry of the MEM-stage data memory and its word-index helper
package dmem_pkg;
  localparam int ADDR_WIDTH      = 64;
  localparam int DATA_WIDTH      = 64;
  localparam int WORD_BYTES_2POW = 3;
  localparam int DEPTH_2POW      = 12;
  function automatic logic [63:0] word_index(input logic [63:0] addr, input int wb2, input int d2);
    return (addr >> wb2) & ((64'd1 << d2) - 64'd1);
  endfunction
endpackage

// File: rtl/data_memory_array.sv
// data_memory_array: word storage with one synchronous write port and one asynchronous read port
module data_memory_array #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_2POW = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DEPTH_2POW-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);
  localparam int DEPTH = 1 << DEPTH_2POW;
  logic [WIDTH-1:0] mem [DEPTH];
  // reset clears every word at once; otherwise write the addressed word on the clock
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we)
      mem[addr] <= wdata;
  // asynchronous read of the addressed word
  always_comb rdata = mem[addr];
endmodule

// File: rtl/data_memory.sv
// data_memory: aligned word memory with combinational read and same-cycle write-through forwarding
module data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH      = dmem_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH      = dmem_pkg::DATA_WIDTH,
  parameter int WORD_BYTES_2POW = dmem_pkg::WORD_BYTES_2POW,
  parameter int DEPTH_2POW      = dmem_pkg::DEPTH_2POW
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  writeEnable_in,
  input  logic                  readEnable_in,
  output logic [DATA_WIDTH-1:0] data_out
);
  localparam int WORD_BYTES = 1 << WORD_BYTES_2POW;
  localparam int WORD_WIDTH = WORD_BYTES * 8;
  if (DATA_WIDTH != WORD_WIDTH) begin : g_width_check
    $error("data_memory: DATA_WIDTH must equal WORD_WIDTH");
  end
  logic [DEPTH_2POW-1:0] index;
  logic [DATA_WIDTH-1:0] rdata;
  // byte offset and bits above the array range are dropped, so addresses wrap
  always_comb index = DEPTH_2POW'(word_index(64'(address_in), WORD_BYTES_2POW, DEPTH_2POW));
  data_memory_array #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_2POW (DEPTH_2POW)
  ) u_array (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .we    (writeEnable_in),
    .addr  (index),
    .wdata (data_in),
    .rdata (rdata)
  );
  // output is zero in reset or when not reading; a concurrent write is forwarded straight through
  always_comb data_out = !rst_n_in || !readEnable_in ? '0 : writeEnable_in ? data_in : rdata;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed scoreboard bench for data_memory
module tb_data_memory;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [63:0] address = 0;
  logic [63:0] din = 0;
  logic        we = 0;
  logic        re = 0;
  logic [63:0] dout;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] model [4096];
  logic [63:0] exp_q [$];
  string       tag_q [$];

  data_memory dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .address_in     (address),
    .data_in        (din),
    .writeEnable_in (we),
    .readEnable_in  (re),
    .data_out       (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] idx(input logic [63:0] a);
    return a[14:3];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4096; i++) model[i] = '0;
  endtask

  task automatic check_one();
    logic [63:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (dout === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", t, dout, e);
    end
  endtask

  task automatic step(input string tag, input logic [63:0] a, input logic [63:0] d,
                      input logic w, input logic r);
    @(negedge clk);
    address = a; din = d; we = w; re = r;
    exp_q.push_back(!rst_n || !r ? 64'd0 : w ? d : model[idx(a)]);
    tag_q.push_back(tag);
    #1 check_one();
    if (w && rst_n) model[idx(a)] = d;
  endtask

  initial begin
    clear_model();
    step("reset_out", 64'h10, 64'h99, 1'b1, 1'b1);
    step("reset_rd", 64'h10, 64'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1;
    step("post_reset_rd", 64'h10, 64'h0, 1'b0, 1'b1);
    step("raw_wr", 64'h10, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step("raw_rd", 64'h10, 64'h0, 1'b0, 1'b1);
    step("wt_fwd", 64'h28, 64'h1234, 1'b1, 1'b1);
    step("wt_rd", 64'h28, 64'h0, 1'b0, 1'b1);
    step("hold_wr", 64'h8, 64'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("hold_rd", 64'h8, 64'hFF, 1'b0, 1'b1);
    step("align_wr", 64'h18, 64'h55, 1'b1, 1'b0);
    step("align_1f", 64'h1F, 64'h0, 1'b0, 1'b1);
    step("wrap_rd", 64'h18 + 64'd4096 * 8, 64'h0, 1'b0, 1'b1);
    step("wrap_hi", 64'hFFFF_0000_0000_0018, 64'h0, 1'b0, 1'b1);
    step("next_word", 64'h20, 64'h0, 1'b0, 1'b1);
    step("re0_wr", 64'h30, 64'h77, 1'b1, 1'b0);
    step("re0_rd", 64'h30, 64'h0, 1'b0, 1'b0);
    step("re1_rd", 64'h30, 64'h0, 1'b0, 1'b1);
    step("re0_fwd", 64'h40, 64'h5A5A, 1'b1, 1'b0);
    step("unwritten", 64'h100, 64'h0, 1'b0, 1'b1);
    step("last_wr", 64'h7FF8, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1);
    step("last_rd", 64'h7FF8, 64'h0, 1'b0, 1'b1);
    step("first_wr", 64'h0, 64'hFEDC, 1'b1, 1'b0);
    step("first_rd", 64'h8000, 64'h0, 1'b0, 1'b1);
    // asynchronous clear: pulse reset between edges and read before any rising edge
    @(negedge clk);
    address = 64'h10; din = 64'h0; we = 1'b0; re = 1'b1;
    rst_n = 0;
    exp_q.push_back(64'd0); tag_q.push_back("rst_async_out");
    #1 check_one();
    rst_n = 1;
    exp_q.push_back(64'd0); tag_q.push_back("rst_async_clear");
    #1 check_one();
    clear_model();
    rst_n = 0;
    step("rst_blk_wr", 64'h48, 64'h1111, 1'b1, 1'b1);
    step("rst_blk_rd", 64'h48, 64'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1;
    step("clr_10", 64'h10, 64'h0, 1'b0, 1'b1);
    step("clr_28", 64'h28, 64'h0, 1'b0, 1'b1);
    step("clr_08", 64'h8, 64'h0, 1'b0, 1'b1);
    step("clr_18", 64'h18, 64'h0, 1'b0, 1'b1);
    step("clr_30", 64'h30, 64'h0, 1'b0, 1'b1);
    step("clr_48", 64'h48, 64'h0, 1'b0, 1'b1);
    step("clr_7ff8", 64'h7FF8, 64'h0, 1'b0, 1'b1);
    step("clr_00", 64'h0, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [63:0] a;
      logic [63:0] d;
      a = 64'($urandom_range(0, 4095)) << 3;
      d = {$urandom, $urandom};
      step("rnd_wr", a, d, 1'b1, 1'b1);
      step("rnd_rd", a | 64'h5, 64'h0, 1'b0, 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
